// File: rtl/scan_chain_controller.sv
// Scan chain controller: shifts one design's input word into a serial chain of NUM_DESIGNS
// designs, latches it, captures every design's outputs, and returns the selected design's
// outputs one frame later.
// Latency: a frame is (NUM_DESIGNS*IO_WIDTH+2)*2*CLK_DIV+2 clk cycles. ready/outputs
// update in the DONE cycle of the frame after the one that captured them.
// Backpressure: none. Frames run while enable is high, or one frame per enable rising
// edge when SCAN_ONESHOT_EN is defined.
//
// Optional build macro: SCAN_ONESHOT_EN (edge-triggered one-shot frames, one-deep pending).
//
// Ports:
//   clk, resetb                : system clock, asynchronous active-low reset
//   enable                     : run control (level, or rising edge in one-shot builds)
//   active_select, inputs      : design index and its input word, sampled at frame start
//   outputs, ready             : previous frame's read-back of the selected design, 1-clk strobe
//   scan_clk, scan_data_out    : chain shift clock and serial data into the chain head
//   scan_data_in               : serial data from the chain tail
//   scan_select                : chain capture-mode select
//   scan_latch_enable          : design input latch strobe
module scan_chain_controller #(
    parameter int NUM_DESIGNS = 498,
    parameter int IO_WIDTH    = 8,
    parameter int SEL_WIDTH   = 9,
    parameter int CLK_DIV     = 1
) (
    input  logic                 clk,
    input  logic                 resetb,
    input  logic                 enable,
    input  logic [SEL_WIDTH-1:0] active_select,
    input  logic [IO_WIDTH-1:0]  inputs,
    output logic [IO_WIDTH-1:0]  outputs,
    output logic                 ready,
    output logic                 scan_clk,
    output logic                 scan_data_out,
    input  logic                 scan_data_in,
    output logic                 scan_select,
    output logic                 scan_latch_enable
);

    localparam int CHAIN_LEN = NUM_DESIGNS * IO_WIDTH;
    localparam int BIT_W     = $clog2(CHAIN_LEN + 1);
    localparam int PH_W      = $clog2(2 * CLK_DIV + 1);

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * CLK_DIV - 1);
    localparam logic [PH_W-1:0]  PH_HI    = PH_W'(CLK_DIV);
    localparam logic [PH_W-1:0]  PH_PRE   = PH_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        LATCH,
        CAPTURE,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [PH_W-1:0]      phase_q, phase_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [SEL_WIDTH-1:0] sel_q, sel_d;
    logic [IO_WIDTH-1:0]  inputs_q, inputs_d;
    logic [IO_WIDTH-1:0]  rb_q, rb_d;
    logic [IO_WIDTH-1:0]  outputs_q, outputs_d;
    logic                 ready_q, ready_d;
    logic                 primed_q, primed_d;
    logic                 sclk_q, sclk_d;
    logic                 sdo_q, sdo_d;
    logic                 ssel_q, ssel_d;
    logic                 sle_q, sle_d;

    logic                 trigger;
    logic                 samp_hit, drv_hit;
    int                   samp_off, drv_off;

    // Bit i of the shift lands at chain position CHAIN_LEN-1-i once all bits are in,
    // so the first bit shifted belongs to the far end of the chain.
    function automatic logic pos_hit(input logic [BIT_W-1:0] idx, input logic [SEL_WIDTH-1:0] s);
        int q;
        int base;
        q    = CHAIN_LEN - 1 - int'(idx);
        base = int'(s) * IO_WIDTH;
        return (int'(s) < NUM_DESIGNS) && (q >= base) && (q < base + IO_WIDTH);
    endfunction

    function automatic int pos_off(input logic [BIT_W-1:0] idx, input logic [SEL_WIDTH-1:0] s);
        return CHAIN_LEN - 1 - int'(idx) - int'(s) * IO_WIDTH;
    endfunction

`ifdef SCAN_ONESHOT_EN
    logic en_q;
    logic pend_q, pend_d;
    logic en_rise;

    assign en_rise = enable & ~en_q;
    assign trigger = en_rise | pend_q;

    // An edge seen while a frame is busy is held until the FSM is back in IDLE.
    always_comb begin
        pend_d = pend_q;
        if (state_q == IDLE) begin
            pend_d = 1'b0;
        end else if (en_rise) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            en_q   <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            en_q   <= enable;
            pend_q <= pend_d;
        end
    end
`else
    assign trigger = enable;
`endif

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        sel_d     = sel_q;
        inputs_d  = inputs_q;
        rb_d      = rb_q;
        outputs_d = outputs_q;
        ready_d   = 1'b0;
        primed_d  = primed_q;
        samp_hit  = pos_hit(bit_q, sel_q);
        samp_off  = pos_off(bit_q, sel_q);

        unique case (state_q)
            IDLE: begin
                if (trigger) begin
                    sel_d    = active_select;
                    inputs_d = inputs;
                    phase_d  = '0;
                    bit_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                // This edge raises scan_clk; the chain shifts after we sample its tail.
                if (phase_q == PH_PRE) begin
                    for (int j = 0; j < IO_WIDTH; j++) begin
                        if (samp_hit && (samp_off == j)) begin
                            rb_d[j] = scan_data_in;
                        end
                    end
                end
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = LATCH;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            LATCH: begin
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    state_d = CAPTURE;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            CAPTURE: begin
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    state_d = DONE;
                    // Loaded on entry so outputs and ready are valid during DONE itself.
                    if (primed_q) begin
                        ready_d   = 1'b1;
                        outputs_d = (int'(sel_q) < NUM_DESIGNS) ? rb_q : '0;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            DONE: begin
                primed_d = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Chain controls are decoded from the next state so the registered pins line up
        // with the state they belong to.
        sclk_d  = ((state_d == SHIFT) || (state_d == CAPTURE)) && (phase_d >= PH_HI);
        ssel_d  = (state_d == CAPTURE);
        sle_d   = (state_d == LATCH);
        drv_hit = pos_hit(bit_d, sel_d);
        drv_off = pos_off(bit_d, sel_d);
        sdo_d   = 1'b0;
        if (state_d == SHIFT) begin
            for (int j = 0; j < IO_WIDTH; j++) begin
                if (drv_hit && (drv_off == j)) begin
                    sdo_d = inputs_d[j];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            bit_q     <= '0;
            sel_q     <= '0;
            inputs_q  <= '0;
            rb_q      <= '0;
            outputs_q <= '0;
            ready_q   <= 1'b0;
            primed_q  <= 1'b0;
            sclk_q    <= 1'b0;
            sdo_q     <= 1'b0;
            ssel_q    <= 1'b0;
            sle_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            sel_q     <= sel_d;
            inputs_q  <= inputs_d;
            rb_q      <= rb_d;
            outputs_q <= outputs_d;
            ready_q   <= ready_d;
            primed_q  <= primed_d;
            sclk_q    <= sclk_d;
            sdo_q     <= sdo_d;
            ssel_q    <= ssel_d;
            sle_q     <= sle_d;
        end
    end

    assign outputs           = outputs_q;
    assign ready             = ready_q;
    assign scan_clk          = sclk_q;
    assign scan_data_out     = sdo_q;
    assign scan_select       = ssel_q;
    assign scan_latch_enable = sle_q;

endmodule

// File: tb/tb_scan_chain_controller.sv
// Bench for scan_chain_controller: DUT A (4 designs) against a behavioural chain and a
// frame-level reference model; DUT B (3 designs, select 3) exercises the out-of-range path.
// Expectations are queued by the stimulus and consumed by independent monitors.
module tb_scan_chain_controller;

    localparam int LEN_A = 138;   // (32+2)*4+2
    localparam int LEN_B = 106;   // (24+2)*4+2

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    logic       resetb;
    logic       enable_a, enable_b;
    logic [1:0] sel_a, sel_b;
    logic [7:0] in_a, in_b, out_a, out_b;
    logic       rdy_a, rdy_b, sck_a, sck_b, sdo_a, sdo_b, sdi_a, sdi_b;
    logic       ssel_a, ssel_b, sle_a, sle_b;

    scan_chain_controller #(.NUM_DESIGNS(4), .IO_WIDTH(8), .SEL_WIDTH(2), .CLK_DIV(2)) dut_a (
        .clk(clk), .resetb(resetb), .enable(enable_a), .active_select(sel_a), .inputs(in_a),
        .outputs(out_a), .ready(rdy_a), .scan_clk(sck_a), .scan_data_out(sdo_a),
        .scan_data_in(sdi_a), .scan_select(ssel_a), .scan_latch_enable(sle_a)
    );

    scan_chain_controller #(.NUM_DESIGNS(3), .IO_WIDTH(8), .SEL_WIDTH(2), .CLK_DIV(2)) dut_b (
        .clk(clk), .resetb(resetb), .enable(enable_b), .active_select(sel_b), .inputs(in_b),
        .outputs(out_b), .ready(rdy_b), .scan_clk(sck_b), .scan_data_out(sdo_b),
        .scan_data_in(sdi_b), .scan_select(ssel_b), .scan_latch_enable(sle_b)
    );

    // B's tail reads all ones: any sampling on the out-of-range path would show up.
    assign sdi_b = 1'b1;

    typedef struct {
        logic [7:0] val;
        int         cyc;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [31:0] qlat[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- chain of four designs behind DUT A ----------------
    // Design k outputs (latched input + k); position k*8+b is design k bit b.
    logic [31:0] sr_a = '0;
    logic [7:0]  lat_a[4] = '{default: 8'h00};
    int          latch_cnt = 0;

    always @(posedge sck_a) begin
        if (ssel_a) begin
            for (int k = 0; k < 4; k++) sr_a[k*8 +: 8] <= lat_a[k] + 8'(k);
        end else begin
            sr_a <= {sr_a[30:0], sdo_a};
        end
    end
    assign sdi_a = sr_a[31];

    always @(posedge sle_a) begin
        latch_cnt++;
        if (qlat.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL chain_a: latch strobe with no pending frame at cycle %0d", cyc);
        end else begin
            chk("chain_a_contents", sr_a, qlat.pop_front());
        end
        for (int k = 0; k < 4; k++) lat_a[k] = sr_a[k*8 +: 8];
    end

    // ---------------- monitors ----------------
    int overlap_cnt = 0;
    int sdo_b_ones  = 0;

    always @(negedge clk) begin
        if (resetb) begin
            if ((sle_a && ssel_a) || (sle_b && ssel_b)) overlap_cnt++;
            if (sdo_b) sdo_b_ones++;
        end
    end

    always @(negedge clk) begin
        if (rdy_a) begin
            if (qa.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL ready_a: pulse with no pending expectation at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = qa.pop_front();
                chk("outputs_a", 32'(out_a), 32'(e.val));
                chk("ready_a_cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (rdy_b) begin
            if (qb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL ready_b: pulse with no pending expectation at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = qb.pop_front();
                chk("outputs_b", 32'(out_b), 32'(e.val));
                chk("ready_b_cycle", cyc, e.cyc);
            end
        end
    end

    // ---------------- frame-level reference model for DUT A ----------------
    logic [7:0] dout[4] = '{default: 8'h00};  // design outputs as last latched
    int         c0  = 0;                      // cycle stamp of epoch start
    int         efr = 0;                      // frames issued since reset release
    int         tix = 0;
    int         prev_s = 0;
    int         tbl_s[6] = '{2, 2, 3, 3, 0, 0};
    logic [7:0] tbl_x[6] = '{8'h10, 8'h10, 8'h20, 8'h20, 8'hA5, 8'hA5};

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic issue(input int s, input logic [7:0] x);
        logic [31:0] w;
        w = '0;
        w[s*8 +: 8] = x;
        sel_a = 2'(s);
        in_a  = x;
        qlat.push_back(w);
        // The first frame after reset only fills the chain; no ready is owed for it.
        if (efr > 0) qa.push_back('{dout[s], c0 + LEN_A * efr + 137});
        for (int k = 0; k < 4; k++) dout[k] = ((k == s) ? x : 8'h00) + 8'(k);
        efr++;
    endtask

    task automatic issue_next();
        int         s;
        logic [7:0] x;
        if (tix < 6) begin
            s = tbl_s[tix];
            x = tbl_x[tix];
        end else begin
            s = ($urandom_range(0, 1) == 0) ? prev_s : int'($urandom_range(0, 3));
            x = 8'($urandom);
        end
        tix++;
        prev_s = s;
        issue(s, x);
    endtask

    // Runs n back-to-back frames; next frame's values change mid-SHIFT of the current one.
    task automatic run_epoch(input int n);
        c0  = cyc;
        efr = 0;
        enable_a = 1'b1;
        issue_next();
        for (int f = 0; f < n; f++) begin
            wait_cyc(c0 + LEN_A * f + 40);
            if (f < n - 1) issue_next();
            else enable_a = 1'b0;
        end
        wait_cyc(c0 + LEN_A * (n - 1) + 140);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outputs"}, 32'(out_a), 32'h0);
        chk({tag, "_ready"}, 32'(rdy_a), 32'h0);
        chk({tag, "_scan_clk"}, 32'(sck_a), 32'h0);
        chk({tag, "_scan_data_out"}, 32'(sdo_a), 32'h0);
        chk({tag, "_scan_select"}, 32'(ssel_a), 32'h0);
        chk({tag, "_latch_enable"}, 32'(sle_a), 32'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        resetb   = 1'b1;
        enable_a = 1'b0;
        enable_b = 1'b0;
        sel_a    = '0;
        in_a     = '0;
        sel_b    = 2'd3;
        in_b     = 8'h5C;
        #2 resetb = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        chk("reset_outputs_b", 32'(out_b), 32'h0);
        resetb = 1'b1;
        repeat (2) @(negedge clk);

`ifndef SCAN_ONESHOT_EN
        begin
            int c0b;
            c0b = cyc;
            enable_b = 1'b1;
            qb.push_back('{8'h00, c0b + LEN_B + 105});
            qb.push_back('{8'h00, c0b + 2 * LEN_B + 105});
            fork
                begin
                    wait_cyc(c0b + 300);
                    enable_b = 1'b0;
                end
            join_none
        end

        run_epoch(14);

        // Abort a frame mid-SHIFT while scan_clk is high, then restart from scratch.
        begin
            int cs;
            cs = cyc;
            enable_a = 1'b1;
            sel_a = 2'd1;
            in_a  = 8'h5A;
            wait_cyc(cs + 51);
            resetb = 1'b0;
            #1;
            chk_all_zero("midreset");
            repeat (3) @(negedge clk);
            qa.delete();
            qlat.delete();
            resetb = 1'b1;
            run_epoch(4);
        end
`else
        // Held-high enable: exactly one frame.
        c0  = cyc;
        efr = 0;
        enable_a = 1'b1;
        issue(1, 8'h33);
        repeat (400) @(negedge clk);
        chk("oneshot_held_frames", latch_cnt, 1);
        enable_a = 1'b0;
        repeat (5) @(negedge clk);
        // Two pulses 10 clks apart: second is remembered and runs straight after the first.
        c0 = cyc - LEN_A;
        enable_a = 1'b1;
        issue(1, 8'h33);
        repeat (2) @(negedge clk);
        enable_a = 1'b0;
        repeat (8) @(negedge clk);
        enable_a = 1'b1;
        issue(2, 8'h44);
        repeat (2) @(negedge clk);
        enable_a = 1'b0;
        repeat (400) @(negedge clk);
        chk("oneshot_pulse_frames", latch_cnt, 3);
`endif

        repeat (5) @(negedge clk);
        chk("pending_ready_a", qa.size(), 0);
        chk("pending_latch_a", qlat.size(), 0);
        chk("pending_ready_b", qb.size(), 0);
        chk("latch_select_overlap", overlap_cnt, 0);
        chk("oob_scan_data_out_ones", sdo_b_ones, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
